// File: rtl/uram_stream_pkg.sv
// Shared types and constants for the URAM read streamer.
package uram_stream_pkg;

    localparam int URAM_WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_e;

    typedef struct packed {
        logic [URAM_WORD_WIDTH-1:0] data;
        logic                       last;
    } uram_stream_entry;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with count/full/empty, used as the skid buffer that
// absorbs the fixed URAM read latency.
module stream_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [16:0],
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next-state for pointers and occupancy; pushes into full and pops from empty are dropped.
    always_comb begin
        push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
        pop_ok_s  = pop_i && (count_q != '0);
        wr_ptr_d  = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset clears contents so no stale word can leak out.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    stream_fifo_chk u_chk (
        .clock  (clock),
        .reset  (reset),
        .push_i (push_i),
        .full_i (full_o)
    );

endmodule

// File: rtl/stream_fifo_chk.sv
// Checker for stream_fifo: a push must never arrive while the FIFO is full.
module stream_fifo_chk (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  logic full_i
);

    property p_no_push_when_full;
        @(posedge clock) disable iff (!reset) !(push_i && full_i);
    endproperty

    a_no_push_when_full: assert property (p_no_push_when_full);

endmodule

// File: rtl/uram_read_streamer.sv
// Streams a contiguous run of URAM words onto a valid/ready output, issuing one
// read per cycle while FIFO credits allow and absorbing the read latency in a skid FIFO.
module uram_read_streamer
    import uram_stream_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 14,
    parameter int READ_LATENCY  = 2,
    parameter int FIFO_DEPTH    = READ_LATENCY + 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]   cmd_base,
    input  logic [ADDRESS_WIDTH:0]     cmd_len,
    output logic [ADDRESS_WIDTH-1:0]   uram_raddr,
    input  logic [URAM_WORD_WIDTH-1:0] uram_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [URAM_WORD_WIDTH-1:0] out_data,
    output logic                       out_last,
    output logic                       busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(READ_LATENCY + 1);

    stream_state_e            state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_s;
    logic [READ_LATENCY-1:0]  sr_valid_q;
    logic [READ_LATENCY-1:0]  sr_last_q;
    logic [INF_W-1:0]         inflight_s;
    logic                     issue_s;
    logic                     issue_last_s;
    logic                     cmd_ready_s;
    logic                     credit_ok_s;
    logic                     pop_s;
    uram_stream_entry         push_entry_s;
    uram_stream_entry         head_s;
    logic [CNT_W-1:0]         fifo_count_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;

    // Number of reads still travelling through the URAM pipeline.
    function automatic logic [INF_W-1:0] count_valid(input logic [READ_LATENCY-1:0] v);
        logic [INF_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            n = n + INF_W'(v[i]);
        end
        return n;
    endfunction

    assign inflight_s  = count_valid(sr_valid_q);
    // Registered occupancy only: a pop this cycle does not free a credit until next cycle.
    assign credit_ok_s = !fifo_full_s &&
                         ((32'(fifo_count_s) + 32'(inflight_s)) < 32'(FIFO_DEPTH));

    // FSM next-state, command acceptance and read issue.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        cmd_ready_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                // A zero-length command is consumed here and produces nothing.
                if (cmd_valid && (cmd_len != '0)) begin
                    addr_d      = cmd_base;
                    remaining_d = cmd_len;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (credit_ok_s) begin
                    issue_s     = 1'b1;
                    addr_d      = addr_q + ADDRESS_WIDTH'(1);
                    remaining_d = remaining_q - (ADDRESS_WIDTH + 1)'(1);
                    if (remaining_q == (ADDRESS_WIDTH + 1)'(1)) begin
                        issue_last_s = 1'b1;
                        state_d      = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                // Leave as the final word pops so cmd_ready is back the very next cycle.
                if ((inflight_s == '0) &&
                    (fifo_empty_s || ((fifo_count_s == CNT_W'(1)) && pop_s))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign raddr_s = issue_s ? addr_q : raddr_q;

    // FSM, address and length registers; raddr holds its last value between issues.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            raddr_q     <= raddr_s;
        end
    end

    // Latency-matched shift register tagging each issued read with {valid, last}.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sr_valid_q <= '0;
            sr_last_q  <= '0;
        end else begin
            sr_valid_q[0] <= issue_s;
            sr_last_q[0]  <= issue_last_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                sr_valid_q[i] <= sr_valid_q[i-1];
                sr_last_q[i]  <= sr_last_q[i-1];
            end
        end
    end

    assign push_entry_s = '{data: uram_dout, last: sr_last_q[READ_LATENCY-1]};
    assign pop_s        = out_valid && out_ready;

    stream_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (uram_stream_entry)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (sr_valid_q[READ_LATENCY-1]),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // All outputs are forced quiet while reset is held.
    assign cmd_ready  = reset && cmd_ready_s;
    assign uram_raddr = reset ? raddr_s : '0;
    assign out_valid  = reset && !fifo_empty_s;
    assign out_data   = reset ? head_s.data : '0;
    assign out_last   = out_valid && head_s.last;
    assign busy       = reset && ((state_q != ST_IDLE) || !fifo_empty_s || (inflight_s != '0));

endmodule
